basic_system_input_pio: RTL and testbench

Parametrised Avalon-MM slave input port for the basic_system platform: samples WIDTH asynchronous board inputs (switches, buttons), synchronises and optionally debounces them, and exposes the stable value to the CPU. Per-bit edge capture is software-clearable, and a maskable level interrupt is raised on any captured edge. Sits on the system interconnect next to the other PIO slaves; its register map is compatible with the single-bit read-only switch port at address 0.

---
 rtl/basic_system_input_pio_if.sv | 17 +
 rtl/basic_system_input_pio.sv | 111 +++++++++++
 tb/tb_basic_system_input_pio.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/basic_system_input_pio_if.sv
// Avalon-MM slave bus bundle shared by the basic_system PIO ports.
interface basic_system_input_pio_if;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned DATA_W = 32;

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              irq;

  modport master (output address, chipselect, write_n, writedata,
                  input  readdata, irq);
  modport slave  (input  address, chipselect, write_n, writedata,
                  output readdata, irq);
endinterface

// File: rtl/basic_system_input_pio.sv
// Avalon-MM input PIO: synchronises and optionally debounces board inputs,
// captures edges per bit (W1C) and raises a maskable level interrupt.
module basic_system_input_pio #(
  parameter int unsigned WIDTH           = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 0,
  parameter int unsigned EDGE_TYPE       = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  basic_system_input_pio_if.slave bus,
  input  logic [WIDTH-1:0]        in_port
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  logic [WIDTH-1:0]  sync1;
  logic [WIDTH-1:0]  sync2;
  logic [WIDTH-1:0]  stable;
  logic [WIDTH-1:0]  prev;
  logic [WIDTH-1:0]  edge_det;
  logic [WIDTH-1:0]  irq_mask;
  logic [WIDTH-1:0]  edge_capture;
  logic [WIDTH-1:0]  clr_mask;
  logic [DATA_W-1:0] rd_mux;
  logic              wr_en;
  logic              unused_wdata;

  // Two-flop synchroniser for the asynchronous board inputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_no_db
      assign stable = sync2;
    end else begin : g_db
      logic [CNT_W-1:0] cnt [WIDTH];
      logic [WIDTH-1:0] stable_q;

      // A bit is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          stable_q <= '0;
          for (int i = 0; i < int'(WIDTH); i++) cnt[i] <= '0;
        end else begin
          for (int i = 0; i < int'(WIDTH); i++) begin
            if (sync2[i] == stable_q[i]) begin
              cnt[i] <= '0;
            end else if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
              stable_q[i] <= sync2[i];
              cnt[i]      <= '0;
            end else begin
              cnt[i] <= cnt[i] + CNT_W'(1);
            end
          end
        end
      end

      assign stable = stable_q;
    end
  endgenerate

  always_comb begin
    edge_det = '0;
    case (EDGE_TYPE)
      32'd0:   edge_det = stable & ~prev;
      32'd1:   edge_det = ~stable & prev;
      default: edge_det = stable ^ prev;
    endcase
  end

  assign wr_en        = bus.chipselect & ~bus.write_n;
  assign clr_mask     = (wr_en && (bus.address == ADDR_EDGE)) ? bus.writedata[WIDTH-1:0] : '0;
  assign unused_wdata = ^bus.writedata;

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      ADDR_DATA: rd_mux = DATA_W'(stable);
      ADDR_MASK: rd_mux = DATA_W'(irq_mask);
      ADDR_EDGE: rd_mux = DATA_W'(edge_capture);
      default:   rd_mux = '0;
    endcase
  end

  // A new edge is ORed in after the clear so a coincident W1C cannot lose it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev         <= '0;
      irq_mask     <= '0;
      edge_capture <= '0;
      bus.readdata <= '0;
    end else begin
      prev         <= stable;
      edge_capture <= (edge_capture & ~clr_mask) | edge_det;
      if (wr_en && (bus.address == ADDR_MASK)) irq_mask <= bus.writedata[WIDTH-1:0];
      bus.readdata <= rd_mux;
    end
  end

  assign bus.irq = |(edge_capture & irq_mask);
endmodule

// File: tb/tb_basic_system_input_pio.sv
// Bench for basic_system_input_pio: four parameterisations driven in lockstep,
// directed table, hand-written corner sequences and random traffic vs a model.
module tb_basic_system_input_pio;
  localparam int unsigned W = 4;
  localparam int NDUT = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [W-1:0] in_port;
  logic [31:0] rd    [NDUT];
  logic        irq_v [NDUT];

  always #5 clk = ~clk;

  // dut0: D=0 rise, dut1: D=4 rise, dut2: D=0 fall, dut3: D=0 any
  function automatic int unsigned db_of(input int i);
    return (i == 1) ? 4 : 0;
  endfunction
  function automatic int unsigned et_of(input int i);
    return (i == 2) ? 1 : (i == 3) ? 2 : 0;
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int unsigned GD = (g == 1) ? 4 : 0;
    localparam int unsigned GE = (g == 2) ? 1 : (g == 3) ? 2 : 0;
    basic_system_input_pio_if bus ();
    assign bus.address    = address;
    assign bus.chipselect = chipselect;
    assign bus.write_n    = write_n;
    assign bus.writedata  = writedata;
    basic_system_input_pio #(.WIDTH(W), .DEBOUNCE_CYCLES(GD), .EDGE_TYPE(GE)) u_dut (
      .clk(clk), .reset_n(reset_n), .bus(bus), .in_port(in_port));
    assign rd[g]    = bus.readdata;
    assign irq_v[g] = bus.irq;
  end

  // Reference model state, one copy per parameterisation
  logic [W-1:0]  m_st   [NDUT];
  logic [W-1:0]  m_pst  [NDUT];
  logic [W-1:0]  m_cap  [NDUT];
  logic [W-1:0]  m_mask [NDUT];
  logic [31:0]   m_rd   [NDUT];
  logic [W-1:0]  m_last_in;
  logic [W-1:0]  s2_hist[$];
  int n_vec = 0;
  int n_err = 0;
  int hold  = 0;
  logic [W-1:0] rin = '0;

  typedef struct {
    logic [W-1:0] in_v;
    logic [1:0]   a;
    logic         cs;
    logic         wn;
    logic [31:0]  wd;
    logic [31:0]  exp_rd;
    logic         exp_irq;
  } vec_t;
  vec_t tbl [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] edge_of(input int unsigned et, input logic [W-1:0] cur,
                                           input logic [W-1:0] old);
    case (et)
      0:       return cur & ~old;
      1:       return ~cur & old;
      default: return cur ^ old;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NDUT; i++) begin
      m_st[i] = '0; m_pst[i] = '0; m_cap[i] = '0; m_mask[i] = '0; m_rd[i] = '0;
    end
    s2_hist.delete();
    repeat (8) s2_hist.push_back('0);
    m_last_in = '0;
  endtask

  // One clock edge: the input seen two edges late is the synchronised value;
  // a debounced bit flips once the last D synchronised samples all disagree.
  task automatic model_edge();
    logic          wr;
    logic [W-1:0]  s2_now, clr, nst;
    wr     = chipselect && !write_n;
    s2_now = m_last_in;
    clr    = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
    for (int i = 0; i < NDUT; i++) begin
      case (address)
        2'd0:    m_rd[i] = 32'(m_st[i]);
        2'd2:    m_rd[i] = 32'(m_mask[i]);
        2'd3:    m_rd[i] = 32'(m_cap[i]);
        default: m_rd[i] = '0;
      endcase
      m_cap[i] = (m_cap[i] & ~clr) | edge_of(et_of(i), m_st[i], m_pst[i]);
      if (wr && address == 2'd2) m_mask[i] = writedata[W-1:0];
      if (db_of(i) == 0) begin
        nst = s2_now;
      end else begin
        nst = m_st[i];
        for (int b = 0; b < int'(W); b++) begin
          bit all_diff = 1'b1;
          for (int j = 0; j < int'(db_of(i)); j++)
            if (s2_hist[s2_hist.size() - 1 - j][b] == m_st[i][b]) all_diff = 1'b0;
          if (all_diff) nst[b] = ~m_st[i][b];
        end
      end
      m_pst[i] = m_st[i];
      m_st[i]  = nst;
    end
    s2_hist.push_back(s2_now);
    if (s2_hist.size() > 16) void'(s2_hist.pop_front());
    m_last_in = in_port;
  endtask

  task automatic compare_all();
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("dut%0d readdata", i), rd[i], m_rd[i]);
      check($sformatf("dut%0d irq", i), {31'b0, irq_v[i]}, {31'b0, |(m_cap[i] & m_mask[i])});
    end
  endtask

  task automatic cycle(input logic [W-1:0] in_v, input logic [1:0] a, input logic cs,
                       input logic wn, input logic [31:0] wd);
    @(negedge clk);
    in_port = in_v; address = a; chipselect = cs; write_n = wn; writedata = wd;
    @(posedge clk);
    if (!reset_n) model_reset();
    else          model_edge();
    #1;
    compare_all();
  endtask

  task automatic rd_cyc(input logic [W-1:0] in_v, input logic [1:0] a);
    cycle(in_v, a, 1'b1, 1'b1, 32'h0);
  endtask

  task automatic wr_cyc(input logic [W-1:0] in_v, input logic [1:0] a, input logic [31:0] wd);
    cycle(in_v, a, 1'b1, 1'b0, wd);
  endtask

  initial begin
    tbl[0]  = '{4'h5, 2'd0, 1'b0, 1'b1, 32'h0,        32'h0, 1'b0};
    tbl[1]  = '{4'h5, 2'd0, 1'b0, 1'b1, 32'h0,        32'h0, 1'b0};
    tbl[2]  = '{4'h5, 2'd0, 1'b0, 1'b1, 32'h0,        32'h5, 1'b0};
    tbl[3]  = '{4'h5, 2'd3, 1'b0, 1'b1, 32'h0,        32'h5, 1'b0};
    tbl[4]  = '{4'h5, 2'd2, 1'b1, 1'b0, 32'h4,        32'h0, 1'b1};
    tbl[5]  = '{4'h5, 2'd2, 1'b0, 1'b1, 32'h0,        32'h4, 1'b1};
    tbl[6]  = '{4'h5, 2'd3, 1'b1, 1'b0, 32'h4,        32'h5, 1'b0};
    tbl[7]  = '{4'h5, 2'd3, 1'b0, 1'b1, 32'h0,        32'h1, 1'b0};
    tbl[8]  = '{4'h5, 2'd0, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h5, 1'b0};
    tbl[9]  = '{4'h5, 2'd1, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b0};
    tbl[10] = '{4'h5, 2'd2, 1'b0, 1'b1, 32'h0,        32'h4, 1'b0};
    tbl[11] = '{4'h5, 2'd3, 1'b0, 1'b1, 32'h0,        32'h1, 1'b0};
    tbl[12] = '{4'h5, 2'd3, 1'b1, 1'b0, 32'hF,        32'h1, 1'b0};
    tbl[13] = '{4'h5, 2'd3, 1'b0, 1'b1, 32'h0,        32'h0, 1'b0};

    reset_n = 1'b0; in_port = '0; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    model_reset();
    for (int c = 0; c < 4; c++) begin
      rd_cyc('0, 2'(c));
      check("reset readdata", rd[0], 32'h0);
      check("reset irq", {31'b0, irq_v[0]}, 32'h0);
    end
    reset_n = 1'b1;

    // Directed register-map walk on the undebounced rising-edge port
    for (int t = 0; t < 14; t++) begin
      cycle(tbl[t].in_v, tbl[t].a, tbl[t].cs, tbl[t].wn, tbl[t].wd);
      check($sformatf("table row %0d readdata", t), rd[0], tbl[t].exp_rd);
      check($sformatf("table row %0d irq", t), {31'b0, irq_v[0]}, {31'b0, tbl[t].exp_irq});
    end

    // Debounce: short pulse rejected, long pulse accepted
    repeat (10) rd_cyc('0, 2'd0);
    wr_cyc('0, 2'd3, 32'hF);
    repeat (3) rd_cyc(4'h1, 2'd0);
    for (int t = 0; t < 10; t++) begin
      rd_cyc('0, 2'd0);
      check("short pulse data", rd[1], 32'h0);
    end
    rd_cyc('0, 2'd3);
    check("short pulse capture", rd[1], 32'h0);
    wr_cyc('0, 2'd3, 32'hF);
    for (int t = 0; t < 14; t++) begin
      rd_cyc((t < 6) ? 4'h1 : 4'h0, 2'd0);
      check($sformatf("long pulse data t%0d", t), {31'b0, rd[1][0]},
            {31'b0, (t >= 6 && t <= 11) ? 1'b1 : 1'b0});
    end
    rd_cyc('0, 2'd3);
    check("long pulse capture", rd[1], 32'h1);

    // Edge modes on bit 3
    repeat (10) rd_cyc('0, 2'd0);
    wr_cyc('0, 2'd3, 32'hF);
    repeat (4) rd_cyc(4'h8, 2'd0);
    rd_cyc(4'h8, 2'd3);
    check("rise edge type0", rd[0], 32'h8);
    check("rise edge type1", rd[2], 32'h0);
    check("rise edge type2", rd[3], 32'h8);
    wr_cyc(4'h8, 2'd3, 32'hF);
    repeat (4) rd_cyc('0, 2'd0);
    rd_cyc('0, 2'd3);
    check("fall edge type0", rd[0], 32'h0);
    check("fall edge type1", rd[2], 32'h8);
    check("fall edge type2", rd[3], 32'h8);

    // Interrupt masking
    repeat (10) rd_cyc('0, 2'd0);
    wr_cyc('0, 2'd3, 32'hF);
    wr_cyc('0, 2'd2, 32'h2);
    repeat (4) rd_cyc(4'h1, 2'd0);
    check("irq masked out", {31'b0, irq_v[0]}, 32'h0);
    wr_cyc(4'h1, 2'd2, 32'h3);
    check("irq after mask write", {31'b0, irq_v[0]}, 32'h1);
    rd_cyc(4'h1, 2'd3);
    check("capture before clear", rd[0], 32'h1);
    wr_cyc(4'h1, 2'd3, 32'h1);
    check("irq after w1c", {31'b0, irq_v[0]}, 32'h0);
    rd_cyc(4'h1, 2'd3);
    check("capture after w1c", rd[0], 32'h0);

    // Coincident W1C and new edge on bit 0
    repeat (4) rd_cyc('0, 2'd0);
    repeat (4) rd_cyc(4'h1, 2'd0);
    check("irq before collision", {31'b0, irq_v[0]}, 32'h1);
    repeat (4) rd_cyc('0, 2'd0);
    rd_cyc(4'h1, 2'd0);
    rd_cyc(4'h1, 2'd0);
    wr_cyc(4'h1, 2'd3, 32'h1);
    check("irq set beats clear", {31'b0, irq_v[0]}, 32'h1);
    rd_cyc(4'h1, 2'd3);
    check("capture set beats clear", rd[0], 32'h1);

    // Asynchronous reset in the middle of a debounce interval
    wr_cyc(4'h1, 2'd2, 32'hF);
    rd_cyc(4'h3, 2'd2);
    rd_cyc(4'h3, 2'd2);
    check("mask before reset", rd[0], 32'hF);
    #2 reset_n = 1'b0;
    #1;
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("dut%0d async reset readdata", i), rd[i], 32'h0);
      check($sformatf("dut%0d async reset irq", i), {31'b0, irq_v[i]}, 32'h0);
    end
    model_reset();
    repeat (3) rd_cyc(4'h3, 2'd2);
    reset_n = 1'b1;
    rd_cyc(4'h3, 2'd2);
    check("mask after reset", rd[0], 32'h0);
    repeat (10) rd_cyc(4'h3, 2'd3);
    check("held-high input captured", rd[0], 32'h3);

    // Random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      if (hold == 0) begin
        rin  = W'($urandom_range(0, 15));
        hold = int'($urandom_range(1, 9));
      end
      hold--;
      cycle(rin, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 2) != 0), $urandom());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
